glu_host_seq: RTL and testbench

- Host-side initiator that drives the sound GLU register interface (select/wr/host_addr/host_data), the other end of the GLU responder.
- Turns one command into the GLU access sequence: busy poll, control write, address low/high writes, then N data-register writes or reads with auto-increment.
- Sits between CPU/DMA glue and the sound block and bulk-loads wavetable RAM or DOC registers without CPU byte-banging.
- Runs on CLK_14M and issues at most one GLU access per ph0_en.

---
 rtl/glu_pkg.sv | 40 ++++
 rtl/glu_access_port.sv | 55 +++++
 rtl/glu_host_seq.sv | 162 ++++++++++++++++
 tb/tb_glu_host_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glu_pkg.sv
// Shared GLU register map, control-byte layout and sequencer state encoding
// used by the host-side GLU initiator.
package glu_pkg;

  localparam logic [1:0] GLU_CTRL = 2'd0;
  localparam logic [1:0] GLU_DATA = 2'd1;
  localparam logic [1:0] GLU_ALO  = 2'd2;
  localparam logic [1:0] GLU_AHI  = 2'd3;

  localparam int CTRL_BUSY   = 7;
  localparam int CTRL_RAM    = 6;
  localparam int CTRL_AINC   = 5;
  localparam int CTRL_VOL_HI = 3;
  localparam int CTRL_VOL_LO = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_POLL_WAIT,
    S_WR_CTRL,
    S_WR_ALO,
    S_WR_AHI,
    S_DUMMY,
    S_DUMMY_WAIT,
    S_XFER,
    S_XFER_WAIT,
    S_DONE
  } seq_state_e;

  // Control byte for a transfer: auto-increment always on, busy bit written as 0.
  function automatic logic [7:0] ctrl_byte(input logic ram, input logic [3:0] vol);
    logic [7:0] c;
    c = 8'h00;
    c[CTRL_RAM] = ram;
    c[CTRL_AINC] = 1'b1;
    c[CTRL_VOL_HI:CTRL_VOL_LO] = vol;
    return c;
  endfunction

endpackage

// File: rtl/glu_access_port.sv
// GLU bus access port: gates requests onto ph0_en, emits the one-cycle select,
// holds the bus values between accesses and captures read data a cycle late.
module glu_access_port
  import glu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ph0_en,
  input  logic       req,
  input  logic       req_wr,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       ack,
  output logic       cap_valid,
  output logic [7:0] cap_data,
  output logic       glu_select,
  output logic       glu_wr,
  output logic [1:0] glu_addr,
  output logic [7:0] glu_wdata,
  input  logic [7:0] glu_rdata
);

  logic [1:0] addr_q;
  logic [7:0] wdata_q;
  logic       rd_pend;

  // Reset is folded in so an in-flight select drops in the reset cycle itself.
  assign ack        = req & ph0_en & ~reset;
  assign glu_select = ack;
  assign glu_wr     = ack & req_wr;
  assign glu_addr   = ack ? req_addr  : addr_q;
  assign glu_wdata  = ack ? req_wdata : wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= GLU_CTRL;
      wdata_q   <= 8'h00;
      rd_pend   <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= 8'h00;
    end else begin
      rd_pend   <= ack & ~req_wr;
      cap_valid <= rd_pend;
      if (ack) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // The responder presents read data during the cycle after the select.
      if (rd_pend) cap_data <= glu_rdata;
    end
  end

endmodule

// File: rtl/glu_host_seq.sv
// Host-side GLU initiator: turns one command into busy poll, control write,
// address writes and an auto-incrementing burst of data writes or reads.
module glu_host_seq
  import glu_pkg::*;
#(
  parameter int POLL_MAX = 255,
  parameter int LEN_W    = 9
) (
  input  logic             CLK_14M,
  input  logic             reset,
  input  logic             ph0_en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_ram,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cfg_volume,
  input  logic [7:0]       wdata,
  input  logic             wvalid,
  output logic             wready,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             done,
  output logic             err,
  output logic             glu_select,
  output logic             glu_wr,
  output logic [1:0]       glu_addr,
  output logic [7:0]       glu_wdata,
  input  logic [7:0]       glu_rdata
);

  localparam int PW = $clog2(POLL_MAX + 1);

  seq_state_e       state, state_nxt;
  logic             wr_q, ram_q;
  logic [15:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [PW-1:0]    poll_q;

  logic             req, req_wr, ack, cap_valid;
  logic [1:0]       req_addr;
  logic [7:0]       req_wdata, cap_data;
  logic             accept, poll_last, last_byte, busy_seen, byte_done;

  glu_access_port u_port (
    .clk        (CLK_14M),
    .reset      (reset),
    .ph0_en     (ph0_en),
    .req        (req),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .glu_select (glu_select),
    .glu_wr     (glu_wr),
    .glu_addr   (glu_addr),
    .glu_wdata  (glu_wdata),
    .glu_rdata  (glu_rdata)
  );

  assign accept    = cmd_valid & cmd_ready;
  assign poll_last = (poll_q == PW'(POLL_MAX - 1));
  assign last_byte = (len_q == LEN_W'(1));
  assign busy_seen = (state == S_POLL_WAIT) & cap_valid & cap_data[CTRL_BUSY];
  assign byte_done = ((state == S_XFER) & wr_q & ack) | ((state == S_XFER_WAIT) & cap_valid);

  // Access request decode depends on state only, keeping ack out of this path.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    req       = 1'b0;
    req_wr    = 1'b0;
    req_addr  = GLU_CTRL;
    req_wdata = 8'h00;
    cmd_ready = (state == S_IDLE);
    done      = (state == S_DONE);
    unique case (state)
      S_POLL:    req = 1'b1;
      S_WR_CTRL: begin
        req = 1'b1; req_wr = 1'b1; req_wdata = ctrl_byte(ram_q, cfg_volume);
      end
      S_WR_ALO:  begin
        req = 1'b1; req_wr = 1'b1; req_addr = GLU_ALO; req_wdata = addr_q[7:0];
      end
      S_WR_AHI:  begin
        req = 1'b1; req_wr = 1'b1; req_addr = GLU_AHI; req_wdata = addr_q[15:8];
      end
      S_DUMMY:   begin
        req = 1'b1; req_addr = GLU_DATA;
      end
      S_XFER:    begin
        req       = wr_q ? wvalid : 1'b1;
        req_wr    = wr_q;
        req_addr  = GLU_DATA;
        req_wdata = wr_q ? wdata : 8'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wready    = 1'b0;
    unique case (state)
      S_IDLE:       if (cmd_valid) state_nxt = (cmd_len == '0) ? S_DONE : S_POLL;
      S_POLL:       if (ack) state_nxt = S_POLL_WAIT;
      S_POLL_WAIT:  if (cap_valid) begin
        if (!cap_data[CTRL_BUSY]) state_nxt = S_WR_CTRL;
        else                      state_nxt = poll_last ? S_DONE : S_POLL;
      end
      S_WR_CTRL:    if (ack) state_nxt = S_WR_ALO;
      S_WR_ALO:     if (ack) state_nxt = ram_q ? S_WR_AHI : (wr_q ? S_XFER : S_DUMMY);
      S_WR_AHI:     if (ack) state_nxt = wr_q ? S_XFER : S_DUMMY;
      S_DUMMY:      if (ack) state_nxt = S_DUMMY_WAIT;
      S_DUMMY_WAIT: if (cap_valid) state_nxt = S_XFER;
      S_XFER:       if (ack) begin
        wready    = wr_q;
        state_nxt = !wr_q ? S_XFER_WAIT : (last_byte ? S_DONE : S_XFER);
      end
      S_XFER_WAIT:  if (cap_valid) state_nxt = last_byte ? S_DONE : S_XFER;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      state  <= S_IDLE;
      wr_q   <= 1'b0;
      ram_q  <= 1'b0;
      addr_q <= 16'h0000;
      len_q  <= '0;
      poll_q <= '0;
      err    <= 1'b0;
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      rvalid <= 1'b0;
      if (accept) begin
        wr_q   <= cmd_write;
        ram_q  <= cmd_ram;
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        poll_q <= '0;
        err    <= 1'b0;
      end
      if (busy_seen) begin
        if (poll_last) err <= 1'b1;
        else           poll_q <= poll_q + 1'b1;
      end
      if (byte_done) len_q <= len_q - 1'b1;
      if ((state == S_XFER_WAIT) && cap_valid) begin
        rdata  <= cap_data;
        rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glu_host_seq.sv
// Self-checking bench for glu_host_seq: GLU responder model, access logger and
// an access-list reference model built from the command rules.
module tb_glu_host_seq;
  import glu_pkg::*;

  localparam int POLL_MAX = 4;
  localparam int LEN_W    = 9;

  logic             clk;
  logic             reset, ph0_en, cmd_valid, cmd_ready, cmd_write, cmd_ram;
  logic [15:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [3:0]       cfg_volume;
  logic [7:0]       wdata, rdata, glu_wdata, glu_rdata;
  logic             wvalid, wready, rvalid, done, err, glu_select, glu_wr;
  logic [1:0]       glu_addr;

  glu_host_seq #(.POLL_MAX(POLL_MAX), .LEN_W(LEN_W)) dut (
    .CLK_14M    (clk),
    .reset      (reset),
    .ph0_en     (ph0_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_ram    (cmd_ram),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cfg_volume (cfg_volume),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .done       (done),
    .err        (err),
    .glu_select (glu_select),
    .glu_wr     (glu_wr),
    .glu_addr   (glu_addr),
    .glu_wdata  (glu_wdata),
    .glu_rdata  (glu_rdata)
  );

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    bit          w;
    bit          ram;
    logic [15:0] addr;
    int          len;
    logic [3:0]  vol;
    int          busy_for;
    logic [23:0] first3;
    int          exp_n;
    bit          exp_err;
    logic [7:0]  exp_ctrl;
  } vec_t;

  acc_t       log_q[$], exp_q[$];
  logic [7:0] wq[$], rq[$], wsrc[$], rsrc[$], rd_got[$], rd_exp[$];
  int         done_cnt, wready_cnt, busy_left, cyc;
  int         ph0_div = 4, ph0_cnt;
  bit         stall, wgap_rand, ph0_rand, rd_pend, cur_exp_err;
  logic [7:0] rd_next;
  int         checks, errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Stimulus driver: ph0 strobe, responder read data, write stream.
  initial begin
    ph0_en = 1'b0; glu_rdata = 8'h00; wvalid = 1'b0; wdata = 8'h00;
    ph0_cnt = 0; cyc = 0; rd_pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (ph0_rand) ph0_en = ($urandom_range(0, 3) == 0);
      else begin
        ph0_en  = (ph0_cnt == 0);
        ph0_cnt = (ph0_cnt + 1) % ph0_div;
      end
      if (rd_pend) begin glu_rdata = rd_next; rd_pend = 1'b0; end
      if (wq.size() > 0 && !stall && (!wgap_rand || $urandom_range(0, 1) == 1)) begin
        wvalid = 1'b1; wdata = wq[0];
      end else begin
        wvalid = 1'b0; wdata = 8'($urandom);
      end
    end
  end

  // Monitor + GLU responder: logs each select pulse and serves reads.
  initial begin
    acc_t a;
    forever begin
      @(negedge clk);
      if (glu_select) begin
        a.wr = glu_wr; a.addr = glu_addr; a.data = glu_wdata;
        if (!glu_wr) begin
          if (glu_addr == GLU_CTRL) begin
            if (busy_left > 0) begin
              busy_left--;
              rd_next = 8'h80 | 8'($urandom_range(0, 127));
            end else rd_next = 8'($urandom_range(0, 127));
          end else if (glu_addr == GLU_DATA) rd_next = (rq.size() > 0) ? rq.pop_front() : 8'hEE;
          else rd_next = 8'h00;
          rd_pend = 1'b1;
          a.data  = rd_next;
        end
        log_q.push_back(a);
      end
      if (wready) begin
        wready_cnt++;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (rvalid) rd_got.push_back(rdata);
      if (done) done_cnt++;
    end
  end

  // Reference: the GLU access list a command must produce.
  task automatic build_expect(input bit w, input bit ram, input logic [15:0] addr,
                              input int len, input logic [3:0] vol, input int busy_for);
    exp_q.delete(); rd_exp.delete(); cur_exp_err = 1'b0;
    if (len == 0) return;
    if (busy_for >= POLL_MAX) begin
      for (int i = 0; i < POLL_MAX; i++) exp_q.push_back('{1'b0, GLU_CTRL, 8'h00});
      cur_exp_err = 1'b1;
      return;
    end
    for (int i = 0; i <= busy_for; i++) exp_q.push_back('{1'b0, GLU_CTRL, 8'h00});
    exp_q.push_back('{1'b1, GLU_CTRL, {1'b0, ram, 1'b1, 1'b0, vol}});
    exp_q.push_back('{1'b1, GLU_ALO, addr[7:0]});
    if (ram) exp_q.push_back('{1'b1, GLU_AHI, addr[15:8]});
    if (!w) exp_q.push_back('{1'b0, GLU_DATA, 8'h00});
    for (int i = 0; i < len; i++) begin
      if (w) exp_q.push_back('{1'b1, GLU_DATA, wsrc[i]});
      else begin
        exp_q.push_back('{1'b0, GLU_DATA, 8'h00});
        rd_exp.push_back(rsrc[i + 1]);
      end
    end
  endtask

  task automatic start_cmd(input bit w, input bit ram, input logic [15:0] addr, input int len,
                           input logic [3:0] vol, input int busy_for, input logic [23:0] first3);
    logic [7:0] b;
    wq.delete(); rq.delete(); wsrc.delete(); rsrc.delete();
    log_q.delete(); rd_got.delete(); done_cnt = 0; wready_cnt = 0;
    for (int i = 0; i <= len; i++) begin
      b = (i < 3) ? first3[23 - 8*i -: 8] : 8'($urandom);
      rsrc.push_back(b);
      if (i < len) wsrc.push_back(b);
    end
    if (w) wq = wsrc; else rq = rsrc;
    busy_left  = busy_for;
    cfg_volume = vol;
    build_expect(w, ram, addr, len, vol, busy_for);
    @(negedge clk);
    check("cmd_ready before command", cmd_ready, 1);
    cmd_write = w; cmd_ram = ram; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = ~w; cmd_ram = ~ram; cmd_addr = 16'($urandom); cmd_len = LEN_W'($urandom);
    check("err cleared on accept", err, 0);
  endtask

  task automatic finish_cmd(input string tag);
    int n, nwr;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
    check({tag, " done within budget"}, done_cnt > 0, 1);
    repeat (4) @(negedge clk);
    check({tag, " access count"}, log_q.size(), exp_q.size());
    nwr = 0;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s acc%0d wr/addr", tag, i), {log_q[i].wr, log_q[i].addr},
            {exp_q[i].wr, exp_q[i].addr});
      if (exp_q[i].wr) check($sformatf("%s acc%0d wdata", tag, i), log_q[i].data, exp_q[i].data);
      if (exp_q[i].wr && exp_q[i].addr == GLU_DATA) nwr++;
    end
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " err"}, err, cur_exp_err);
    check({tag, " wready pulses"}, wready_cnt, nwr);
    check({tag, " rvalid count"}, rd_got.size(), rd_exp.size());
    for (int i = 0; i < rd_exp.size() && i < rd_got.size(); i++)
      check($sformatf("%s rdata%0d", tag, i), rd_got[i], rd_exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, cmd_ready, 1);
    check({tag, " glu_select"}, glu_select, 0);
    check({tag, " glu_wr"}, glu_wr, 0);
    check({tag, " glu_addr"}, glu_addr, 0);
    check({tag, " glu_wdata"}, glu_wdata, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " rvalid"}, rvalid, 0);
    check({tag, " wready"}, wready, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int n, base;
    acc_t found;
    checks = 0; errors = 0;
    stall = 1'b0; wgap_rand = 1'b0; ph0_rand = 1'b0; busy_left = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_ram = 1'b0;
    cmd_addr = 16'h0000; cmd_len = '0; cfg_volume = 4'h0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    //            w  ram addr      len vol   busy first3       n  err ctrl
    vecs.push_back('{1, 1, 16'h1234, 3, 4'hF, 0, 24'hA55AFF, 7,  0, 8'h6F});
    vecs.push_back('{0, 0, 16'h00A0, 2, 4'h5, 0, 24'h112233, 6,  0, 8'h25});
    vecs.push_back('{1, 1, 16'h4000, 2, 4'h3, 9, 24'h010203, 4,  1, 8'h00});
    vecs.push_back('{0, 1, 16'hFFFE, 3, 4'h0, 2, 24'h990080, 10, 0, 8'h60});
    vecs.push_back('{1, 0, 16'h003C, 1, 4'h7, 3, 24'hDEAD00, 7,  0, 8'h27});
    vecs.push_back('{1, 1, 16'h5555, 0, 4'h2, 0, 24'h000000, 0,  0, 8'h00});

    foreach (vecs[k]) begin
      start_cmd(vecs[k].w, vecs[k].ram, vecs[k].addr, vecs[k].len, vecs[k].vol,
                vecs[k].busy_for, vecs[k].first3);
      if (vecs[k].len == 0) check("len0 done next cycle", done, 1);
      finish_cmd($sformatf("vec%0d", k));
      check($sformatf("vec%0d table n_access", k), log_q.size(), vecs[k].exp_n);
      check($sformatf("vec%0d table err", k), err, vecs[k].exp_err);
      if (!vecs[k].exp_err && vecs[k].len > 0) begin
        base = vecs[k].busy_for + 1;
        found = (log_q.size() > base) ? log_q[base] : '{1'b0, 2'd0, 8'h00};
        check($sformatf("vec%0d ctrl write", k), {found.wr, found.addr, found.data},
              {1'b1, GLU_CTRL, vecs[k].exp_ctrl});
      end
    end

    // Write stream stalled for 50 ph0 periods after the address phase.
    stall = 1'b1;
    start_cmd(1, 1, 16'h0800, 2, 4'h9, 1, 24'hC33C7E);
    n = 0;
    while (log_q.size() < 5 && n < 2000) begin @(negedge clk); n++; end
    check("stall address phase", log_q.size(), 5);
    repeat (50 * ph0_div) @(negedge clk);
    check("stall no access", log_q.size(), 5);
    check("stall no wready", wready_cnt, 0);
    stall = 1'b0;
    finish_cmd("stall");

    // Reset during the burst, after byte 2 of 5.
    start_cmd(1, 1, 16'h2000, 5, 4'h1, 0, 24'h102030);
    n = 0;
    while (log_q.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    check("midreset reached byte 2", log_q.size(), 6);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midreset no resume", log_q.size(), 6);
    start_cmd(0, 1, 16'hBEEF, 3, 4'hA, 1, 24'h445566);
    finish_cmd("after reset");

    // Randomized commands with irregular ph0 and write-stream gaps.
    ph0_rand = 1'b1; wgap_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      bit r_w, r_ram;
      int r_len, r_busy;
      r_w    = 1'($urandom_range(0, 1));
      r_ram  = 1'($urandom_range(0, 1));
      r_len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      r_busy = $urandom_range(0, 5);
      start_cmd(r_w, r_ram, 16'($urandom), r_len, 4'($urandom), r_busy, 24'($urandom));
      finish_cmd($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
